// File: rtl/sync_filter_edge.sv
// Per-channel async-input synchronizer with optional persistence filter and rise/fall pulse decode.
// Latency STAGES edges (+FILTER_LEN when filtering) from a stable input to sync_out; no backpressure.
module sync_filter_edge #(
  parameter int CHANNELS   = 1,
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 0,
  parameter bit RESET_VAL  = 1'b0
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter_edge: STAGES must be >= 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("sync_filter_edge: CHANNELS must be >= 1");
  end
  if (FILTER_LEN < 0) begin : g_bad_filter
    $error("sync_filter_edge: FILTER_LEN must be >= 0");
  end

  localparam int CNT_W = (FILTER_LEN > 0) ? $clog2(FILTER_LEN + 1) : 1;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [STAGES-1:0] r_sync;
    logic              w_level;
    logic              w_filt;
    logic              r_hist;

    // Only r_sync[0] ever looks at the asynchronous pin.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= {STAGES{RESET_VAL}};
      end else begin
        r_sync <= {r_sync[STAGES-2:0], async_in[gi]};
      end
    end

    assign w_level = r_sync[STAGES-1];

    if (FILTER_LEN == 0) begin : g_nofilt
      assign w_filt = w_level;
    end else begin : g_filt
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
      logic [CNT_W-1:0] r_cnt;
      logic             r_filt;

      // Counts consecutive cycles the chain disagrees with the accepted level; any agreement restarts it.
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt  <= '0;
          r_filt <= RESET_VAL;
        end else if (w_level == r_filt) begin
          r_cnt  <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_filt <= w_level;
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end

      assign w_filt = r_filt;
    end

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        r_hist <= RESET_VAL;
      end else begin
        r_hist <= w_filt;
      end
    end

    // History resets to the same value as the filtered level, so reset release never pulses.
    assign sync_out[gi]   = w_filt;
    assign rise_pulse[gi] = w_filt & ~r_hist;
    assign fall_pulse[gi] = ~w_filt & r_hist;
  end

endmodule
